// File: rtl/branch_predictor_unit.sv
// rtl/branch_predictor_unit.sv - gshare direction predictor with direct-mapped BTB and speculative GHR; optional return address stack under BPU_RAS_EN
module branch_predictor_unit #(
  parameter int INDEX_BITS  = 8,
  parameter int BTB_ENTRIES = 16,
  parameter int RAS_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fetch_valid,
  input  logic [31:0]           fetch_pc,
  output logic                  pred_valid,
  output logic                  pred_hit,
  output logic                  pred_taken,
  output logic [31:0]           pred_target,
  output logic [INDEX_BITS-1:0] pred_ghr,
  input  logic                  upd_valid,
  input  logic [31:0]           upd_pc,
  input  logic [1:0]            upd_type,
  input  logic                  upd_taken,
  input  logic [31:0]           upd_target,
  input  logic [INDEX_BITS-1:0] upd_ghr,
  input  logic                  upd_mispredict
);

  localparam int PHT_SIZE = 1 << INDEX_BITS;
  localparam int BI       = $clog2(BTB_ENTRIES);
  localparam int TW       = 30 - BI;

  logic [1:0]             r_pht     [PHT_SIZE];
  logic [BTB_ENTRIES-1:0] r_btb_v;
  logic [TW-1:0]          r_btb_tag [BTB_ENTRIES];
  logic [31:0]            r_btb_tgt [BTB_ENTRIES];
  logic [1:0]             r_btb_type[BTB_ENTRIES];
  logic [INDEX_BITS-1:0]  r_ghr;

  logic                   r_pred_valid;
  logic                   r_pred_hit;
  logic                   r_pred_taken;
  logic [31:0]            r_pred_target;
  logic [INDEX_BITS-1:0]  r_pred_ghr;

  // Lookup side: tables are read with the state from before this cycle's update
  logic [BI-1:0]          w_l_bidx;
  logic [INDEX_BITS-1:0]  w_l_pidx;
  logic                   w_l_hit;
  logic [1:0]             w_l_type;
  logic                   w_l_taken;
  logic                   w_l_is_br;
  logic [31:0]            w_l_target;
  logic                   w_repair;
  logic [BI-1:0]          w_u_bidx;
  logic [INDEX_BITS-1:0]  w_u_pidx;
  logic [1:0]             w_u_ctr;
  logic                   w_unused;

  assign w_l_bidx  = fetch_pc[BI+1:2];
  assign w_l_pidx  = fetch_pc[INDEX_BITS+1:2] ^ r_ghr;
  assign w_l_hit   = r_btb_v[w_l_bidx] && (r_btb_tag[w_l_bidx] == fetch_pc[31:BI+2]);
  assign w_l_type  = r_btb_type[w_l_bidx];
  assign w_l_taken = w_l_hit && ((w_l_type != 2'd0) || r_pht[w_l_pidx][1]);
  assign w_l_is_br = w_l_hit && (w_l_type == 2'd0);
  assign w_repair  = upd_valid && upd_mispredict;
  assign w_u_bidx  = upd_pc[BI+1:2];
  assign w_u_pidx  = upd_pc[INDEX_BITS+1:2] ^ upd_ghr;
  assign w_u_ctr   = r_pht[w_u_pidx];

`ifdef BPU_RAS_EN
  localparam int RB = $clog2(RAS_DEPTH);

  logic [31:0]   r_ras [RAS_DEPTH];
  logic [RB-1:0] r_ras_ptr;
  logic [RB:0]   r_ras_cnt;
  logic [RB-1:0] w_ras_top;
  logic          w_ret_hit;
  logic          w_ras_push;
  logic          w_ras_pop;

  assign w_ras_top  = r_ras_ptr - 1'b1;
  assign w_ret_hit  = w_l_hit && (w_l_type == 2'd3) && (r_ras_cnt != '0);
  assign w_ras_push = fetch_valid && w_l_hit && (w_l_type == 2'd2);
  assign w_ras_pop  = fetch_valid && w_ret_hit;
  assign w_l_target = w_ret_hit ? r_ras[w_ras_top] : r_btb_tgt[w_l_bidx];
  assign w_unused   = ^{fetch_pc[1:0], upd_pc[1:0]};

  // Return stack: ptr is the next free slot; on overflow the oldest entry is overwritten
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ras_ptr <= '0;
      r_ras_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
    end else if (w_ras_push) begin
      r_ras[r_ras_ptr] <= fetch_pc + 32'd4;
      r_ras_ptr        <= r_ras_ptr + 1'b1;
      if (r_ras_cnt != (RB+1)'(RAS_DEPTH)) r_ras_cnt <= r_ras_cnt + 1'b1;
    end else if (w_ras_pop) begin
      r_ras_ptr <= w_ras_top;
      r_ras_cnt <= r_ras_cnt - 1'b1;
    end
  end
`else
  assign w_l_target = r_btb_tgt[w_l_bidx];
  assign w_unused   = ^{fetch_pc[1:0], upd_pc[1:0], (RAS_DEPTH > 0)};
`endif

  // Registered prediction outputs; they hold while no lookup is presented
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pred_valid  <= 1'b0;
      r_pred_hit    <= 1'b0;
      r_pred_taken  <= 1'b0;
      r_pred_target <= '0;
      r_pred_ghr    <= '0;
    end else begin
      r_pred_valid <= fetch_valid && !w_repair;
      if (fetch_valid) begin
        r_pred_hit    <= w_l_hit;
        r_pred_taken  <= w_l_taken;
        r_pred_target <= w_l_target;
        r_pred_ghr    <= r_ghr;
      end
    end
  end

  // Global history: repair from the resolving snapshot beats the speculative shift
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ghr <= '0;
    end else if (w_repair) begin
      if (upd_type == 2'd0) r_ghr <= {upd_ghr[INDEX_BITS-2:0], upd_taken};
      else                  r_ghr <= upd_ghr;
    end else if (fetch_valid && w_l_is_br) begin
      r_ghr <= {r_ghr[INDEX_BITS-2:0], w_l_taken};
    end
  end

  // Pattern history counters, trained only by conditional branches
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PHT_SIZE; i++) r_pht[i] <= 2'b01;
    end else if (upd_valid && (upd_type == 2'd0)) begin
      if (upd_taken && (w_u_ctr != 2'b11))       r_pht[w_u_pidx] <= w_u_ctr + 2'b01;
      else if (!upd_taken && (w_u_ctr != 2'b00)) r_pht[w_u_pidx] <= w_u_ctr - 2'b01;
    end
  end

  // Target buffer: every taken resolution allocates; not-taken never touches it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_btb_v <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_btb_tag[i]  <= '0;
        r_btb_tgt[i]  <= '0;
        r_btb_type[i] <= '0;
      end
    end else if (upd_valid && upd_taken) begin
      r_btb_v[w_u_bidx]    <= 1'b1;
      r_btb_tag[w_u_bidx]  <= upd_pc[31:BI+2];
      r_btb_tgt[w_u_bidx]  <= upd_target;
      r_btb_type[w_u_bidx] <= upd_type;
    end
  end

  assign pred_valid  = r_pred_valid;
  assign pred_hit    = r_pred_hit;
  assign pred_taken  = r_pred_taken;
  assign pred_target = r_pred_target;
  assign pred_ghr    = r_pred_ghr;

endmodule

// File: tb/tb_branch_predictor_unit.sv
// tb/tb_branch_predictor_unit.sv - directed vector bench for branch_predictor_unit
module tb_branch_predictor_unit;

  logic        clk;
  logic        reset_n;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        pred_valid;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [7:0]  pred_ghr;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [1:0]  upd_type;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [7:0]  upd_ghr;
  logic        upd_mispredict;

  int n_tests = 0;
  int n_fail  = 0;

  branch_predictor_unit #(.INDEX_BITS(8), .BTB_ENTRIES(16), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_ghr(pred_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_type(upd_type), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_ghr(upd_ghr), .upd_mispredict(upd_mispredict)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        fv;
    logic [31:0] fpc;
    logic        uv;
    logic [31:0] upc;
    logic [1:0]  ut;
    logic        utk;
    logic [31:0] utg;
    logic [7:0]  ughr;
    logic        um;
    logic        ev;
    logic        eh;
    logic        et;
    logic [31:0] etg;
    logic [7:0]  eg;
    logic        chk;
    logic        chk_tgt;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(logic fv, logic [31:0] fpc, logic uv, logic [31:0] upc,
                              logic [1:0] ut, logic utk, logic [31:0] utg, logic [7:0] ughr,
                              logic um, logic ev, logic eh, logic et, logic [31:0] etg,
                              logic [7:0] eg, logic chk, logic chk_tgt);
    vec_t v;
    v.fv = fv; v.fpc = fpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utk = utk; v.utg = utg;
    v.ughr = ughr; v.um = um; v.ev = ev; v.eh = eh; v.et = et; v.etg = etg; v.eg = eg;
    v.chk = chk; v.chk_tgt = chk_tgt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    fetch_valid    = v.fv;
    fetch_pc       = v.fpc;
    upd_valid      = v.uv;
    upd_pc         = v.upc;
    upd_type       = v.ut;
    upd_taken      = v.utk;
    upd_target     = v.utg;
    upd_ghr        = v.ughr;
    upd_mispredict = v.um;
    @(posedge clk);
    #1;
    fetch_valid = 1'b0;
    upd_valid   = 1'b0;
  endtask

  task automatic check(input vec_t v, input string tag);
    chk({tag, ".valid"}, {31'd0, pred_valid}, {31'd0, v.ev});
    if (v.chk) begin
      chk({tag, ".hit"},   {31'd0, pred_hit},   {31'd0, v.eh});
      chk({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, v.et});
      chk({tag, ".ghr"},   {24'd0, pred_ghr},   {24'd0, v.eg});
      if (v.chk_tgt) chk({tag, ".target"}, pred_target, v.etg);
    end
  endtask

  task automatic look(input logic [31:0] pc, input logic eh, input logic et,
                      input logic [31:0] etg, input string tag);
    vec_t v;
    v = mk(1, pc, 0, 0, 0, 0, 0, 0, 0, 1, eh, et, etg, 8'h00, 1, 1);
    apply(v);
    check(v, tag);
  endtask

  task automatic train(input logic [31:0] pc, input logic [1:0] ty, input logic [31:0] tg);
    vec_t v;
    v = mk(0, 0, 1, pc, ty, 1, tg, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(v);
  endtask

  initial begin
    vec_t v;
    reset_n = 1'b0;
    fetch_valid = 0; fetch_pc = 0; upd_valid = 0; upd_pc = 0; upd_type = 0;
    upd_taken = 0; upd_target = 0; upd_ghr = 0; upd_mispredict = 0;

    //           fv fpc      uv upc      ut tk tgt      ughr   um ev eh et etg       eg    chk ct
    vecs[0]  = mk(1, 32'h40,  0, 0,       0, 0, 0,       8'h00, 0, 1, 0, 0, 0,       8'h00, 1, 0);
    vecs[1]  = mk(0, 0,       1, 32'h40,  0, 1, 32'h80,  8'h00, 0, 0, 0, 0, 0,       8'h00, 1, 0);
    vecs[2]  = mk(0, 0,       1, 32'h40,  0, 1, 32'h80,  8'h00, 0, 0, 0, 0, 0,       8'h00, 1, 0);
    vecs[3]  = mk(1, 32'h40,  0, 0,       0, 0, 0,       8'h00, 0, 1, 1, 1, 32'h80,  8'h00, 1, 1);
    vecs[4]  = mk(1, 32'h40,  1, 32'h44,  1, 1, 32'h300, 8'h00, 1, 0, 0, 0, 0,       8'h00, 0, 0);
    vecs[5]  = mk(1, 32'h40,  0, 0,       0, 0, 0,       8'h00, 0, 1, 1, 1, 32'h80,  8'h00, 1, 1);
    vecs[6]  = mk(0, 0,       1, 32'h40,  0, 1, 32'h80,  8'h00, 0, 0, 1, 1, 32'h80,  8'h00, 1, 1);
    vecs[7]  = vecs[6];
    vecs[8]  = vecs[6];
    vecs[9]  = vecs[6];
    vecs[10] = mk(0, 0,       1, 32'h40,  0, 0, 32'h80,  8'h00, 1, 0, 1, 1, 32'h80,  8'h00, 1, 1);
    vecs[11] = mk(1, 32'h40,  0, 0,       0, 0, 0,       8'h00, 0, 1, 1, 1, 32'h80,  8'h00, 1, 1);
    vecs[12] = mk(1, 32'h40,  0, 0,       0, 0, 0,       8'h00, 0, 1, 1, 0, 32'h80,  8'h01, 1, 1);
    vecs[13] = mk(1, 32'h44,  0, 0,       0, 0, 0,       8'h00, 0, 1, 1, 1, 32'h300, 8'h02, 1, 1);
    vecs[14] = mk(0, 0,       0, 0,       0, 0, 0,       8'h00, 0, 0, 1, 1, 32'h300, 8'h02, 1, 1);
    vecs[15] = mk(0, 0,       1, 32'h40,  0, 0, 0,       8'h5A, 1, 0, 1, 1, 32'h300, 8'h02, 1, 1);
    vecs[16] = mk(1, 32'h80,  0, 0,       0, 0, 0,       8'h00, 0, 1, 0, 0, 0,       8'hB4, 1, 0);
    vecs[17] = mk(1, 32'h40,  1, 32'h40,  0, 0, 0,       8'h5A, 1, 0, 0, 0, 0,       8'h00, 0, 0);
    vecs[18] = mk(1, 32'h80,  0, 0,       0, 0, 0,       8'h00, 0, 1, 0, 0, 0,       8'hB4, 1, 0);
    vecs[19] = mk(0, 0,       1, 32'h100, 0, 1, 32'h500, 8'h00, 0, 0, 0, 0, 0,       8'hB4, 1, 0);
    vecs[20] = mk(0, 0,       1, 32'h140, 0, 1, 32'h600, 8'h00, 0, 0, 0, 0, 0,       8'hB4, 1, 0);
    vecs[21] = mk(1, 32'h100, 0, 0,       0, 0, 0,       8'h00, 0, 1, 0, 0, 0,       8'hB4, 1, 0);
    vecs[22] = mk(1, 32'h140, 0, 0,       0, 0, 0,       8'h00, 0, 1, 1, 0, 32'h600, 8'hB4, 1, 1);
    vecs[23] = mk(0, 0,       1, 32'h140, 0, 0, 0,       8'h00, 0, 0, 1, 0, 32'h600, 8'hB4, 1, 1);
    vecs[24] = mk(1, 32'h140, 0, 0,       0, 0, 0,       8'h00, 0, 1, 1, 0, 32'h600, 8'h68, 1, 1);
    vecs[25] = mk(1, 32'h100, 1, 32'h100, 0, 1, 32'h500, 8'h00, 0, 1, 0, 0, 0,       8'hD0, 1, 0);
    vecs[26] = mk(1, 32'h100, 0, 0,       0, 0, 0,       8'h00, 0, 1, 1, 0, 32'h500, 8'hD0, 1, 1);

    repeat (2) @(posedge clk);
    #1;
    chk("reset.valid",  {31'd0, pred_valid}, 32'd0);
    chk("reset.hit",    {31'd0, pred_hit},   32'd0);
    chk("reset.taken",  {31'd0, pred_taken}, 32'd0);
    chk("reset.target", pred_target,         32'd0);
    chk("reset.ghr",    {24'd0, pred_ghr},   32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 27; i++) begin
      apply(vecs[i]);
      check(vecs[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset mid-run: outputs clear without a clock edge
    #3 reset_n = 1'b0;
    #1;
    chk("midrst.valid",  {31'd0, pred_valid}, 32'd0);
    chk("midrst.hit",    {31'd0, pred_hit},   32'd0);
    chk("midrst.taken",  {31'd0, pred_taken}, 32'd0);
    chk("midrst.target", pred_target,         32'd0);
    chk("midrst.ghr",    {24'd0, pred_ghr},   32'd0);
    #2 reset_n = 1'b1;
    v = mk(1, 32'h140, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 1, 0);
    apply(v);
    check(v, "postrst");

    // Call / return pair
    train(32'h200, 2'd2, 32'h1000);
    train(32'h1004, 2'd3, 32'hAA0);
    look(32'h200, 1, 1, 32'h1000, "call0");
`ifdef BPU_RAS_EN
    look(32'h1004, 1, 1, 32'h204, "ret0");
    train(32'h208, 2'd2, 32'h1000);
    train(32'h210, 2'd2, 32'h1000);
    train(32'h218, 2'd2, 32'h1000);
    train(32'h220, 2'd2, 32'h1000);
    for (int i = 0; i < 5; i++) look(32'h200 + 32'(8 * i), 1, 1, 32'h1000, $sformatf("call%0d", i + 1));
    for (int i = 0; i < 4; i++) look(32'h1004, 1, 1, 32'h224 - 32'(8 * i), $sformatf("ret%0d", i + 1));
    look(32'h1004, 1, 1, 32'hAA0, "ret_underflow");
`else
    look(32'h1004, 1, 1, 32'hAA0, "ret0");
    look(32'h1004, 1, 1, 32'hAA0, "ret1");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
